// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared widths, size/state encodings and alignment helper for the LSU.
`ifndef LSU_PARAMETERS_VH
`define LSU_PARAMETERS_VH
`define ADDRESS_WIDTH 10
`define WORD_WIDTH 32
`define HALF_WIDTH 16
`define BYTE_WIDTH 8
`define WE_width 4
`define SIZE_BYTE 2'b00
`define SIZE_HALF 2'b01
`define SIZE_WORD 2'b10
`define LSU_IDLE 3'd0
`define LSU_ACC0 3'd1
`define LSU_ACC1 3'd2
`define LSU_WAIT 3'd3
`define LSU_RESP 3'd4
`endif
package load_store_unit_pkg;
  localparam int AW = `ADDRESS_WIDTH;
  localparam int WW = `WORD_WIDTH;
  localparam int WAW = `ADDRESS_WIDTH - 2;
  typedef enum logic [2:0] {
    IDLE = `LSU_IDLE,
    ACC0 = `LSU_ACC0,
    ACC1 = `LSU_ACC1,
    WAIT = `LSU_WAIT,
    RESP = `LSU_RESP
  } lsu_state_e;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == `SIZE_HALF ? off == 2'd3 : size == `SIZE_WORD ? off != 2'd0 : 1'b0;
  endfunction
endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: byte-lane mask and store lane data from (size, off); load extraction from a two-word pair.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]      size_i,
  input  logic [1:0]      off_i,
  input  logic            unsigned_i,
  input  logic [WW-1:0]   wdata_i,
  input  logic [2*WW-1:0] pair_i,
  output logic [6:0]      mask_o,
  output logic [WW-1:0]   lane0_o,
  output logic [WW-1:0]   lane1_o,
  output logic [WW-1:0]   rdata_o
);
  logic [3:0] base;
  logic [2*WW-1:0] wide;
  logic [WW-1:0] shr;
  always_comb begin
    base = size_i == `SIZE_BYTE ? 4'b0001 : size_i == `SIZE_HALF ? 4'b0011 : 4'b1111;
    mask_o = {3'b000, base} << off_i;
    wide = {{WW{1'b0}}, wdata_i} << {off_i, 3'b000};
    shr = WW'(pair_i >> {off_i, 3'b000});
    rdata_o = size_i == `SIZE_BYTE ? {{(WW-`BYTE_WIDTH){~unsigned_i & shr[`BYTE_WIDTH-1]}}, shr[`BYTE_WIDTH-1:0]}
            : size_i == `SIZE_HALF ? {{(WW-`HALF_WIDTH){~unsigned_i & shr[`HALF_WIDTH-1]}}, shr[`HALF_WIDTH-1:0]}
            : shr;
  end
  assign lane0_o = wide[WW-1:0];
  assign lane1_o = wide[2*WW-1:WW];
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store front end for a one-cycle-latency word memory,
// splitting misaligned accesses into two word accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [1:0]             req_size_i,
  input  logic                   req_unsigned_i,
  input  logic [`ADDRESS_WIDTH-1:0]   req_addr_i,
  input  logic [`WORD_WIDTH-1:0]      req_wdata_i,
  output logic                   resp_valid_o,
  output logic                   resp_err_o,
  output logic [`WORD_WIDTH-1:0]      resp_rdata_o,
  output logic [`ADDRESS_WIDTH-3:0]   mem_A_o,
  output logic [`WORD_WIDTH-1:0]      mem_W_o,
  output logic [`WE_width-1:0]        mem_WE_o,
  input  logic [`WORD_WIDTH-1:0]      mem_R_i
);
  lsu_state_e state_q;
  logic [AW-1:0] addr_q;
  logic [1:0] size_q;
  logic we_q, uns_q, err_q, mis, illegal;
  logic [WW-1:0] wdata_q, lo_q, rdata_q, lane0, lane1, ext;
  logic [WAW-1:0] w0;
  logic [6:0] mask;
  assign w0 = addr_q[AW-1:2];
  assign mis = misaligned(size_q, addr_q[1:0]);
  assign illegal = req_size_i == 2'b11 || (!ALLOW_MISALIGNED && misaligned(req_size_i, req_addr_i[1:0]));
  assign req_ready_o = state_q == IDLE && !rst;
  lsu_align u_align (
    .size_i    (size_q),
    .off_i     (addr_q[1:0]),
    .unsigned_i(uns_q),
    .wdata_i   (wdata_q),
    .pair_i    (mis ? {mem_R_i, lo_q} : {{WW{1'b0}}, mem_R_i}),
    .mask_o    (mask),
    .lane0_o   (lane0),
    .lane1_o   (lane1),
    .rdata_o   (ext)
  );
  // In WAIT the last word is still on mem_R, so the result is extracted straight into the response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q <= 1'b0;
      rdata_q <= '0;
      we_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          addr_q <= req_addr_i;
          size_q <= req_size_i;
          we_q <= req_we_i;
          uns_q <= req_unsigned_i;
          wdata_q <= req_wdata_i;
          err_q <= illegal;
          rdata_q <= '0;
          state_q <= illegal ? RESP : ACC0;
        end
        ACC0: state_q <= mis ? ACC1 : we_q ? RESP : WAIT;
        ACC1: begin
          lo_q <= mem_R_i;
          state_q <= we_q ? RESP : WAIT;
        end
        WAIT: begin
          rdata_q <= ext;
          state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_A_o = state_q == ACC1 ? w0 + WAW'(1) : w0;
  assign mem_W_o = state_q == ACC1 ? lane1 : lane0;
  assign mem_WE_o = (rst || !we_q) ? 4'b0000 : state_q == ACC0 ? mask[3:0] : state_q == ACC1 ? {1'b0, mask[6:4]} : 4'b0000;
  assign resp_valid_o = state_q == RESP;
  assign resp_err_o = err_q;
  assign resp_rdata_o = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a byte-level memory model.
module tb_load_store_unit;
  typedef struct {
    logic v;
    logic e;
    logic [31:0] rd;
    logic ca;
    logic [7:0] a;
    logic [3:0] we;
    logic [31:0] w;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_valid0 = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [9:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_err, req_ready0, resp_valid0, resp_err0;
  logic [31:0] resp_rdata, mem_W, mem_R, resp_rdata0, mem_W0;
  logic [7:0] mem_A, mem_A0;
  logic [3:0] mem_WE, mem_WE0;
  logic [31:0] envmem [0:255];
  logic [7:0] refm [0:1023];
  logic init_q = 1'b0, pre_we = 1'b0;
  logic [7:0] pre_a = '0;
  logic [31:0] pre_d = '0, last_rdata = '0;
  exp_t q[$];
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_err_o(resp_err), .resp_rdata_o(resp_rdata),
    .mem_A_o(mem_A), .mem_W_o(mem_W), .mem_WE_o(mem_WE), .mem_R_i(mem_R)
  );
  load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid0), .resp_err_o(resp_err0), .resp_rdata_o(resp_rdata0),
    .mem_A_o(mem_A0), .mem_W_o(mem_W0), .mem_WE_o(mem_WE0), .mem_R_i(32'h0)
  );

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] we);
    return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction

  always @(posedge clk) begin
    if (!init_q) begin
      for (int i = 0; i < 256; i++) envmem[i] <= seed_word(i);
      init_q <= 1'b1;
    end else if (pre_we) envmem[pre_a] <= pre_d;
    else for (int i = 0; i < 4; i++) if (mem_WE[i]) envmem[mem_A][8*i +: 8] <= mem_W[8*i +: 8];
    mem_R <= envmem[mem_A];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      chk("rst_we", 32'(mem_WE), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_valid", 32'(resp_valid), 0);
    end else if (q.size() != 0) begin
      x = q.pop_front();
      chk("resp_valid", 32'(resp_valid), 32'(x.v));
      if (x.v) begin
        chk("resp_err", 32'(resp_err), 32'(x.e));
        chk("resp_rdata", resp_rdata, x.rd);
        last_rdata = resp_rdata;
      end
      if (x.ca) chk("mem_A", 32'(mem_A), 32'(x.a));
      chk("mem_WE", 32'(mem_WE), 32'(x.we));
      chk("mem_W", mem_W & lanes(x.we), x.w & lanes(x.we));
    end else begin
      chk("idle_valid", 32'(resp_valid), 0);
      chk("idle_we", 32'(mem_WE), 0);
    end
    chk("nomis_we", 32'(mem_WE0), 0);
  end

  // Byte-level model: each accessed byte lands in the first word or spills into the next one.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns, input logic [9:0] addr, input logic [31:0] wd);
    int n;
    logic [9:0] a;
    logic [7:0] w0;
    logic [3:0] we0, we1;
    logic [31:0] d0, d1, val;
    exp_t x;
    x = '{v: 0, e: 0, rd: 0, ca: 0, a: 0, we: 0, w: 0};
    if (sz == 2'b11) begin
      x.v = 1; x.e = 1;
      q.push_back(x);
      return;
    end
    n = sz == 0 ? 1 : sz == 1 ? 2 : 4;
    w0 = addr[9:2];
    we0 = 0; we1 = 0; d0 = 0; d1 = 0; val = 0;
    for (int i = 0; i < n; i++) begin
      a = addr + 10'(i);
      if (a[9:2] == w0) begin we0[a[1:0]] = 1'b1; d0[8*a[1:0] +: 8] = wd[8*i +: 8]; end
      else begin we1[a[1:0]] = 1'b1; d1[8*a[1:0] +: 8] = wd[8*i +: 8]; end
      val[8*i +: 8] = refm[a];
      if (we) refm[a] = wd[8*i +: 8];
    end
    for (int i = 8*n; i < 32; i++) val[i] = val[8*n-1] & ~uns;
    x.ca = 1; x.a = w0; x.we = we ? we0 : 4'b0; x.w = d0;
    q.push_back(x);
    if (int'(addr[1:0]) + n > 4) begin
      x.a = w0 + 8'd1; x.we = we ? we1 : 4'b0; x.w = d1;
      q.push_back(x);
    end
    x.ca = 0; x.we = 0; x.w = 0;
    if (!we) q.push_back(x);
    x.v = 1; x.rd = we ? 32'h0 : val;
    q.push_back(x);
  endtask

  task automatic req(input logic we, input logic [1:0] sz, input logic uns, input logic [9:0] addr, input logic [31:0] wd);
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 1);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    model(we, sz, uns, addr, wd);
    if ($urandom_range(0, 3) == 0) begin
      req_addr = 10'($urandom); req_wdata = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 0;
    for (int i = 0; i < 12 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: %0d expected cycles left, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic req0(input logic we, input logic [1:0] sz, input logic [9:0] addr);
    @(negedge clk);
    req_valid0 = 1; req_we = we; req_size = sz; req_unsigned = 0; req_addr = addr; req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid0 = 0;
    @(negedge clk);
    chk("nomis_valid", 32'(resp_valid0), 1);
    chk("nomis_err", 32'(resp_err0), 1);
    chk("nomis_rdata", resp_rdata0, 0);
    chk("nomis_busy", 32'(req_ready0), 0);
    @(negedge clk);
    chk("nomis_done", 32'(resp_valid0), 0);
    chk("nomis_ready", 32'(req_ready0), 1);
  endtask

  task automatic set_word(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1; pre_a = a; pre_d = d;
    @(posedge clk); #1;
    pre_we = 0;
    for (int i = 0; i < 4; i++) refm[{a, 2'(i)}] = d[8*i +: 8];
  endtask

  initial begin
    exp_t x;
    for (int i = 0; i < 256; i++) for (int b = 0; b < 4; b++) refm[4*i+b] = seed_word(i) >> (8*b);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", 32'(resp_err), 0);
    set_word(8'h04, 32'h8899AABB);
    set_word(8'h05, 32'h11223344);
    req(0, 2'b00, 0, 10'h013, 0);
    chk("lit_lb", last_rdata, 32'hFFFFFF88);
    req(0, 2'b00, 1, 10'h013, 0);
    chk("lit_lbu", last_rdata, 32'h00000088);
    req(0, 2'b01, 1, 10'h013, 0);
    chk("lit_lhu_split", last_rdata, 32'h00004488);
    req(1, 2'b10, 0, 10'h012, 32'hDEADBEEF);
    req(0, 2'b10, 0, 10'h012, 0);
    chk("lit_lw_split", last_rdata, 32'hDEADBEEF);
    chk("lit_sw_w4", envmem[4], 32'hBEEFAABB);
    chk("lit_sw_w5", envmem[5], 32'h1122DEAD);
    set_word(8'hFF, 32'h44332211);
    set_word(8'h00, 32'h88776655);
    req(0, 2'b10, 0, 10'h3FD, 0);
    chk("lit_lw_wrap", last_rdata, 32'h55443322);
    req(0, 2'b11, 0, 10'h010, 0);
    req(1, 2'b11, 0, 10'h010, 32'h12345678);
    req0(1, 2'b01, 10'h003);
    req0(0, 2'b11, 10'h010);
    // Reset lands in the second half of a split store: only the first word keeps its write.
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'b10; req_addr = 10'h012; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 0;
    x = '{v: 0, e: 0, rd: 0, ca: 1, a: 8'h04, we: 4'b1100, w: 32'hF00D0000};
    q.push_back(x);
    refm[10'h012] = 8'h0D;
    refm[10'h013] = 8'hF0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 1);
    chk("post_rst_valid", 32'(resp_valid), 0);
    chk("post_rst_w4", envmem[4], 32'hF00DAABB);
    chk("post_rst_w5", envmem[5], 32'h1122DEAD);
    for (int k = 0; k < 300; k++) begin
      logic [1:0] sz;
      int r;
      r = $urandom_range(0, 15);
      sz = r == 15 ? 2'b11 : 2'(r % 3);
      req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
          $urandom_range(0, 1) ? 10'($urandom_range(0, 63)) : 10'(10'h3C0 + $urandom_range(0, 63)), $urandom);
    end
    @(negedge clk);
    for (int i = 0; i < 256; i++)
      chk("mem_image", envmem[i], {refm[4*i+3], refm[4*i+2], refm[4*i+1], refm[4*i]});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
